// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, validates
// 11-bit frames, folds E0/F0 prefixes into key events and queues the
// events in a first-word-fall-through FIFO with error reporting.
module ps2_keyboard_rx #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_code,
    output logic                          out_break,
    output logic                          out_ext,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_err,
    output logic [ERR_CNT_W-1:0]          err_cnt,
    input  logic                          err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0} pstate_t;

    logic [2:0]           clk_sync_q;
    logic [1:0]           dat_sync_q;
    logic                 strobe;
    logic                 data_bit;
    logic [3:0]           bit_cnt_q,  bit_cnt_d;
    logic [9:0]           frame_q,    frame_d;
    logic [TW-1:0]        to_cnt_q,   to_cnt_d;
    logic                 byte_done_q, byte_done_d;
    logic                 frame_err_q, frame_err_d;
    logic [7:0]           byte_q,     byte_d;
    logic                 frame_good;
    pstate_t              state_q,    state_d;
    logic                 push, push_ext, push_brk;
    logic [9:0]           mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 overflow_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic                 full, pop, do_push;

    // Line synchronisers; both reset to the idle-high level of the bus.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
        end
    end

    // Falling edge of the synchronised PS/2 clock: older stage high, newer low.
    assign strobe   = clk_sync_q[2] & ~clk_sync_q[1];
    assign data_bit = dat_sync_q[1];

    // Start low, stop high, odd parity over data plus parity bit.
    assign frame_good = ~frame_q[0] & data_bit & (^frame_q[9:1]);

    // Bit collection, frame judgement and partial-frame timeout.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        frame_d     = frame_q;
        to_cnt_d    = to_cnt_q;
        byte_done_d = 1'b0;
        frame_err_d = 1'b0;
        byte_d      = byte_q;
        if (strobe) begin
            to_cnt_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d   = 4'd0;
                byte_done_d = frame_good;
                frame_err_d = ~frame_good;
                byte_d      = frame_q[8:1];
            end else begin
                frame_d[bit_cnt_q] = data_bit;
                bit_cnt_d          = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                bit_cnt_d   = 4'd0;
                to_cnt_d    = '0;
                frame_err_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    // Frame receiver state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_cnt_q   <= 4'd0;
            frame_q     <= '0;
            to_cnt_q    <= '0;
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            byte_q      <= 8'd0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            to_cnt_q    <= to_cnt_d;
            byte_done_q <= byte_done_d;
            frame_err_q <= frame_err_d;
            byte_q      <= byte_d;
        end
    end

    // Prefix FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Prefix FSM next state: E0 always restarts an extended sequence, F0 adds break.
    always_comb begin
        state_d = state_q;
        if (frame_err_q) begin
            state_d = ST_IDLE;
        end else if (byte_done_q) begin
            if (byte_q == 8'hE0) begin
                state_d = ST_E0;
            end else if (byte_q == 8'hF0) begin
                case (state_q)
                    ST_E0, ST_E0F0: state_d = ST_E0F0;
                    default:        state_d = ST_F0;
                endcase
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // Prefix FSM outputs: any non-prefix byte becomes an event.
    always_comb begin
        push     = byte_done_q && (byte_q != 8'hE0) && (byte_q != 8'hF0);
        push_ext = (state_q == ST_E0) || (state_q == ST_E0F0);
        push_brk = (state_q == ST_F0) || (state_q == ST_E0F0);
    end

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = out_valid & out_ready;
    assign do_push = push & (~full | pop);

    // Event storage; no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= {push_ext, push_brk, byte_q};
    end

    // FIFO pointers, occupancy, sticky overflow and saturating error count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (err_clr)                    overflow_q <= 1'b0;
            else if (push && full && !pop)  overflow_q <= 1'b1;
            if (err_clr)                                 err_cnt_q <= '0;
            else if (frame_err_q && (err_cnt_q != '1))   err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign out_valid  = (count_q != '0);
    assign {out_ext, out_break, out_code} = out_valid ? mem_q[rd_ptr_q] : 10'd0;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed plus randomized bench for ps2_keyboard_rx with a flag-based
// reference model of prefix folding and an expected-event queue.
module tb_ps2_keyboard_rx;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 200;
    localparam int EW      = 3;
    localparam int H       = 8;   // half period of the PS/2 clock in clk cycles

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            ps2_clk = 1'b1;
    logic            ps2_data = 1'b1;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [7:0]      out_code;
    logic            out_break;
    logic            out_ext;
    logic [3:0]      fifo_count;
    logic            overflow;
    logic            frame_err;
    logic [EW-1:0]   err_cnt;
    logic            err_clr = 1'b0;

    ps2_keyboard_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT), .ERR_CNT_W(EW)) dut (
        .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_break(out_break), .out_ext(out_ext), .fifo_count(fifo_count),
        .overflow(overflow), .frame_err(frame_err), .err_cnt(err_cnt),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int err_pulses = 0;

    logic [9:0] obs_q[$];
    logic [9:0] exp_q[$];

    // reference model state
    bit m_ext = 0, m_brk = 0;
    int m_err = 0, m_pulses = 0, m_level = 0;
    bit m_track = 0, m_ovf = 0;

    // Record every accepted head event and every error pulse.
    always @(negedge clk) begin
        if (resetn) begin
            if (out_valid && out_ready) obs_q.push_back({out_ext, out_break, out_code});
            if (frame_err) err_pulses++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_err(input int e);
        return (e > (1 << EW) - 1) ? (1 << EW) - 1 : e;
    endfunction

    // Drive the first nbits of a frame; optionally pulse out_ready exactly
    // over the FIFO write edge that follows the stop bit.
    task automatic send_bits(input logic [7:0] b, input bit bad, input int nbits, input bit pulse_pop);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            cyc(H);
            ps2_clk = 1'b0;
            if (i == 10 && pulse_pop) begin
                cyc(3);
                out_ready = 1'b1;
                cyc(1);
                out_ready = 1'b0;
                cyc(H - 4);
            end else begin
                cyc(H);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        cyc(H);
    endtask

    // Specification-level meaning of a received (or corrupted) byte.
    task automatic model_byte(input logic [7:0] b, input bit bad);
        if (bad) begin
            m_ext = 0; m_brk = 0; m_err++; m_pulses++;
        end else if (b == 8'hE0) begin
            m_ext = 1; m_brk = 0;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (m_track && m_level >= DEPTH) m_ovf = 1;
            else begin
                exp_q.push_back({m_ext, m_brk, b});
                if (m_track) m_level++;
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic send_key(input logic [7:0] b, input bit bad);
        send_bits(b, bad, 11, 1'b0);
        model_byte(b, bad);
    endtask

    task automatic compare_and_clear(input string tag);
        int n;
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_event"}, 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] rb;
        bit         rbad;

        // reset state
        cyc(3);
        resetn = 1'b1;
        cyc(2);
        check("rst_valid",  32'(out_valid),  32'd0);
        check("rst_count",  32'(fifo_count), 32'd0);
        check("rst_ovf",    32'(overflow),   32'd0);
        check("rst_ferr",   32'(frame_err),  32'd0);
        check("rst_errcnt", 32'(err_cnt),    32'd0);
        check("rst_head",   32'({out_ext, out_break, out_code}), 32'd0);

        // make / break
        send_key(8'h1C, 0); send_key(8'hF0, 0); send_key(8'h1C, 0);
        cyc(10);
        compare_and_clear("makebreak");
        check("mb_count",  32'(fifo_count), 32'd0);
        check("mb_errcnt", 32'(err_cnt),    32'd0);

        // extended make and break
        send_key(8'hE0, 0); send_key(8'h75, 0);
        send_key(8'hE0, 0); send_key(8'hF0, 0); send_key(8'h75, 0);
        cyc(10);
        compare_and_clear("ext");

        // parity error cancels a pending F0
        send_key(8'hF0, 0); send_key(8'h1C, 1); send_key(8'h32, 0);
        cyc(10);
        compare_and_clear("parity");
        check("par_errcnt", 32'(err_cnt),    32'(sat_err(m_err)));
        check("par_pulses", 32'(err_pulses), 32'(m_pulses));

        // timeout on a partial frame
        send_bits(8'h1C, 0, 5, 1'b0);
        cyc(TIMEOUT + 10);
        m_err++; m_pulses++; m_ext = 0; m_brk = 0;
        send_key(8'h1C, 0);
        cyc(10);
        compare_and_clear("timeout");
        check("to_errcnt", 32'(err_cnt),    32'(sat_err(m_err)));
        check("to_pulses", 32'(err_pulses), 32'(m_pulses));

        // overflow with consumer stalled
        out_ready = 1'b0; m_track = 1; m_level = 0; m_ovf = 0;
        for (int k = 1; k <= 9; k++) send_key(8'(k), 0);
        check("ovf_count", 32'(fifo_count), 32'(m_level));
        check("ovf_flag",  32'(overflow),   32'(m_ovf));
        out_ready = 1'b1;
        cyc(DEPTH + 4);
        m_track = 0; m_level = 0;
        compare_and_clear("overflow");
        err_clr = 1'b1; cyc(1); err_clr = 1'b0; m_err = 0; m_ovf = 0;
        check("clr_ovf",    32'(overflow), 32'd0);
        check("clr_errcnt", 32'(err_cnt),  32'd0);

        // full FIFO with push and pop on the same edge
        out_ready = 1'b0; m_track = 1; m_level = 0;
        for (int k = 1; k <= 8; k++) send_key(8'(k), 0);
        check("full_count", 32'(fifo_count), 32'(m_level));
        send_bits(8'h0A, 0, 11, 1'b1);
        m_level--;
        model_byte(8'h0A, 0);
        check("pp_count", 32'(fifo_count), 32'(m_level));
        check("pp_ovf",   32'(overflow),   32'(m_ovf));
        out_ready = 1'b1;
        cyc(DEPTH + 4);
        m_track = 0; m_level = 0;
        compare_and_clear("pushpop");

        // randomized byte stream with prefixes and occasional parity errors
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 9))
                0, 1:    rb = 8'hE0;
                2, 3:    rb = 8'hF0;
                default: rb = 8'($urandom);
            endcase
            rbad = ($urandom_range(0, 9) == 0);
            send_key(rb, rbad);
            check("rnd_evcount", 32'(obs_q.size()), 32'(exp_q.size()));
        end
        cyc(10);
        compare_and_clear("random");
        check("rnd_errcnt", 32'(err_cnt),    32'(sat_err(m_err)));
        check("rnd_pulses", 32'(err_pulses), 32'(m_pulses));

        // error counter saturation
        for (int k = 0; k < 9; k++) send_key(8'h55, 1);
        check("sat_errcnt", 32'(err_cnt), 32'(sat_err(m_err)));
        err_clr = 1'b1; cyc(1); err_clr = 1'b0; m_err = 0;
        check("sat_clr", 32'(err_cnt), 32'd0);

        // reset mid-frame discards FIFO contents, prefix and partial frame
        out_ready = 1'b0;
        send_key(8'h11, 0); send_key(8'hE0, 0); send_key(8'h12, 0);
        send_key(8'hF0, 0);
        send_bits(8'h99, 0, 4, 1'b0);
        resetn = 1'b0;
        cyc(2);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_valid", 32'(out_valid),  32'd0);
        resetn = 1'b1;
        cyc(2);
        exp_q.delete(); m_ext = 0; m_brk = 0; m_err = 0;
        out_ready = 1'b1;
        send_key(8'h21, 0);
        cyc(10);
        compare_and_clear("midreset");
        check("mid_errcnt", 32'(err_cnt), 32'(sat_err(m_err)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Parametrised PS/2 keyboard receiver. It samples the synchronised ps2_clk/ps2_data lines and validates each 11-bit frame: start bit, odd parity and stop bit. It folds the E0 (extended) and F0 (break) prefix bytes into single key events and buffers those events in a FIFO with a valid/ready output. It sits between the board's PS/2 pins and any consumer (ASCII lookup, display, CPU MMIO) and reports framing errors, timeouts and overflow.

## Interface
Parameters:
- FIFO_DEPTH, 8, number of event entries; power of two, at least 2.
- TIMEOUT_CYCLES, 50000, idle clk cycles after which a partial frame is aborted; at least 16.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- out_valid  out  1  FIFO holds at least one event.
- out_ready  in  1  consumer accepts the head event this cycle.
- out_code  out  8  scancode of the head event.
- out_break  out  1  head event is a key release (F0 prefix seen).
- out_ext  out  1  head event is an extended key (E0 prefix seen).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse on a bad frame or a timeout.
- err_cnt  out  ERR_CNT_W  saturating count of frame_err pulses.
- err_clr  in  1  synchronous clear of overflow and err_cnt.

## Operation
- **Synchroniser:** ps2_clk passes through 3 flops and ps2_data through 2 flops. The sample strobe is asserted when stage2 is 1 and stage1 is 0 (falling edge). Data is sampled from the synchronised ps2_data on the strobe cycle.
- **Bit counter (0..10):** bit 0 is start, bits 1–8 are data LSB first, bit 9 is parity, bit 10 is stop. On the strobe for bit 10 the frame is judged.
  - Good frame: start==0, stop==1, and XOR of bits 1..9 is 1.
  - A good frame raises the internal byte_done for one cycle.
  - A bad frame raises frame_err.
  - The counter returns to 0 in both cases.
- **Timeout:** when the counter is non-zero and TIMEOUT_CYCLES consecutive cycles pass with no strobe:
  - the counter is cleared;
  - frame_err pulses;
  - the prefix FSM goes to IDLE.
- **Prefix FSM:** states IDLE, E0, F0, E0F0. It acts only on byte_done.
  - IDLE: E0 goes to E0; F0 goes to F0.
  - E0: F0 goes to E0F0; E0 stays in E0.
  - F0: E0 goes to E0 (restarts the sequence); F0 stays in F0.
  - E0F0: E0 goes to E0; F0 stays in E0F0.
  - Any other byte in any state pushes the event {ext, brk, code} with ext and brk taken from the current state, then returns to IDLE.
  - frame_err forces IDLE and drops any pending prefix.
  - All non-prefix bytes (AA, FA, E1, …) are ordinary codes.
- **FIFO:** circular buffer of FIFO_DEPTH×10 bits with a first-word-fall-through head on out_code/out_break/out_ext.
  - Pop happens when out_valid && out_ready.
  - A push when full with no pop is dropped and sets overflow. Overflow stays set until err_clr or reset.
  - A push and a pop in the same cycle when full both succeed and the count is unchanged.
  - A push and a pop in the same cycle when empty: the push is stored and out_valid is not asserted that cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- **err_cnt:** increments on each frame_err and saturates at all-ones. If err_clr and frame_err occur in the same cycle, err_clr wins and the result is 0.

## Timing
- **Reset values:** out_valid=0, fifo_count=0, overflow=0, frame_err=0, err_cnt=0, out_code/out_break/out_ext=0. Bit counter 0, prefix IDLE, timeout counter 0, synchroniser flops 1 (line idle-high).
- **Strobe latency:** a strobe is asserted 3 clk cycles after a ps2_clk falling edge at the pin (±1 for metastability).
- **Event latency:** with the stop-bit strobe at cycle T:
  - byte_done or frame_err is asserted in cycle T+1;
  - the FIFO write happens on the edge ending T+1;
  - out_valid rises in T+2 if the FIFO was empty.
- **out_ready:** may be held high permanently, giving one pop per cycle while out_valid. Head outputs are stable while out_valid && !out_ready.
- **Reset mid-frame:** asserting resetn low discards the partial frame, prefix state and FIFO contents immediately.

## Test plan
- **Make/break sequence:** send frames 1C, F0 1C (each with correct odd parity, out_ready=1).
  - Events: {code=1C, brk=0, ext=0} then {1C, brk=1, ext=0}.
  - fifo_count returns to 0.
  - err_cnt=0.
- **Extended keys:** send E0 75, then E0 F0 75.
  - Events: {75, ext=1, brk=0} then {75, ext=1, brk=1}.
  - Exactly 2 events total; no events for the prefix bytes.
- **Parity error:** send 1C with the parity bit inverted, then a good 32.
  - One frame_err pulse; err_cnt=1.
  - Only {32,0,0} is delivered.
  - A preceding F0 is cancelled by the error.
- **Timeout:** send 5 bits of a frame, hold ps2_clk high for TIMEOUT_CYCLES+10 cycles, then send a full 1C.
  - One frame_err pulse.
  - The following 1C is received correctly.
- **Overflow:** with out_ready=0 and FIFO_DEPTH=8, send 9 make codes 01..09.
  - fifo_count=8 and overflow=1.
  - Draining yields 01..08 in order.
  - err_clr clears overflow.
- **Full FIFO with simultaneous push/pop:** with the FIFO full, raise out_ready exactly in the push cycle.
  - No drop; overflow stays 0.
  - fifo_count stays 8.
  - Order is preserved.
